// File: rtl/serial_latch_rx.sv
// serial_latch_rx: receive side of the three-wire shift/latch serial link.
// Oversamples SH_CP/ST_CP/DS on Clk, rebuilds DATA_WIDTH-bit words MSB first,
// and presents good words on a valid/ack holding register with frame-error
// and overrun reporting.
module serial_latch_rx #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  SH_CP,
  input  logic                  ST_CP,
  input  logic                  DS,
  input  logic                  Data_ack,
  input  logic                  Ovr_clr,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Data_vld,
  output logic                  Frm_err,
  output logic                  Overrun
);

  // Bit counter saturates one past a full word so long frames stay "bad".
  localparam int unsigned CNT_MAX = DATA_WIDTH + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronizer chains: [0]=sync1, [1]=sync2, [2]=edge-detect history.
  logic [2:0] sh_sync;
  logic [2:0] st_sync;
  logic [1:0] ds_sync;

  logic sh_rise;
  logic st_rise;
  logic ds_bit;

  // Word assembly state.
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;

  // Next-state values.
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0]      bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  vld_nxt;
  logic                  ferr_nxt;
  logic                  ovr_nxt;

  // Latch classification of the current ST_CP rise.
  logic word_good;
  logic frame_bad;

  // Bring the asynchronous link lines into the Clk domain.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sh_sync <= '0;
      st_sync <= '0;
      ds_sync <= '0;
    end else begin
      sh_sync <= {sh_sync[1:0], SH_CP};
      st_sync <= {st_sync[1:0], ST_CP};
      ds_sync <= {ds_sync[0], DS};
    end
  end

  // Rise detection on the synchronized clocks; DS aligns with the SH_CP rise.
  always_comb begin
    sh_rise = sh_sync[1] & ~sh_sync[2];
    st_rise = st_sync[1] & ~st_sync[2];
    ds_bit  = ds_sync[1];
  end

  // Judge a latch on the pre-shift bit count.
  always_comb begin
    word_good = 1'b0;
    frame_bad = 1'b0;
    if (st_rise) begin
      if (bit_cnt == CNT_FULL) begin
        word_good = 1'b1;
      end else if (bit_cnt != '0) begin
        frame_bad = 1'b1;
      end
    end
  end

  // Next-state for shift register, bit counter and the output holding register.
  always_comb begin
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    data_nxt    = Data_out;
    vld_nxt     = Data_vld;
    ferr_nxt    = 1'b0;
    ovr_nxt     = Overrun;

    // A coincident shift becomes bit 1 of the next frame.
    if (st_rise) begin
      bit_cnt_nxt = sh_rise ? CNT_ONE : '0;
    end else if (sh_rise && (bit_cnt != CNT_SAT)) begin
      bit_cnt_nxt = bit_cnt + CNT_ONE;
    end

    if (sh_rise) begin
      shreg_nxt = {shreg[DATA_WIDTH-2:0], ds_bit};
    end

    // A capture keeps valid high even when acked in the same cycle.
    if (word_good) begin
      data_nxt = shreg;
      vld_nxt  = 1'b1;
    end else if (Data_ack && Data_vld) begin
      vld_nxt = 1'b0;
    end

    // Setting the overrun wins over a simultaneous clear.
    if (word_good && Data_vld && !Data_ack) begin
      ovr_nxt = 1'b1;
    end else if (Ovr_clr) begin
      ovr_nxt = 1'b0;
    end

    ferr_nxt = frame_bad;
  end

  // Assembly state registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Data_out <= '0;
      Data_vld <= 1'b0;
      Frm_err  <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      Data_out <= data_nxt;
      Data_vld <= vld_nxt;
      Frm_err  <= ferr_nxt;
      Overrun  <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_serial_latch_rx.sv
// tb_serial_latch_rx: directed and randomized link traffic checked every
// cycle against a frame-level reference model of the receiver.
module tb_serial_latch_rx;

  localparam int unsigned DW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          SH_CP;
  logic          ST_CP;
  logic          DS;
  logic          Data_ack;
  logic          Ovr_clr;
  logic [DW-1:0] Data_out;
  logic          Data_vld;
  logic          Frm_err;
  logic          Overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  logic chk_en = 1'b0;
  logic rand_mode = 1'b0;

  serial_latch_rx #(.DATA_WIDTH(DW)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .SH_CP    (SH_CP),
    .ST_CP    (ST_CP),
    .DS       (DS),
    .Data_ack (Data_ack),
    .Ovr_clr  (Ovr_clr),
    .Data_out (Data_out),
    .Data_vld (Data_vld),
    .Frm_err  (Frm_err),
    .Overrun  (Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line levels seen at each Clk edge; an edge seen at cycle n acts at n+2.
  logic [2:0] h_sh, h_st, h_ds;
  int unsigned m_cnt;          // bits since last latch (unbounded)
  logic [DW-1:0] m_word;       // most recent DW bits
  logic [DW-1:0] m_data;
  logic m_vld, m_ferr, m_ovr;

  logic e_sh, e_st, e_bit;
  int unsigned n_cnt;
  logic [DW-1:0] n_word, n_data;
  logic n_vld, n_ferr, n_ovr;

  always_comb begin
    e_sh  = h_sh[1] && !h_sh[2];
    e_st  = h_st[1] && !h_st[2];
    e_bit = h_ds[1];
    n_cnt  = m_cnt;
    n_word = m_word;
    n_data = m_data;
    n_vld  = m_vld;
    n_ovr  = m_ovr;
    n_ferr = 1'b0;
    if (e_st && m_cnt == DW) begin
      n_data = m_word;
      n_vld  = 1'b1;
      if (m_vld && !Data_ack) n_ovr = 1'b1;
      else if (Ovr_clr) n_ovr = 1'b0;
    end else begin
      if (e_st && m_cnt != 0) n_ferr = 1'b1;
      if (Data_ack) n_vld = 1'b0;
      if (Ovr_clr) n_ovr = 1'b0;
    end
    if (e_st) n_cnt = 0;
    if (e_sh) begin
      n_word = DW'((32'(m_word) * 2 + 32'(e_bit)) % (32'd1 << DW));
      n_cnt  = (n_cnt < 1000) ? n_cnt + 1 : n_cnt;
    end
  end

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      h_sh <= '0; h_st <= '0; h_ds <= '0;
      m_cnt <= 0; m_word <= '0; m_data <= '0;
      m_vld <= 1'b0; m_ferr <= 1'b0; m_ovr <= 1'b0;
    end else begin
      h_sh <= {h_sh[1:0], SH_CP};
      h_st <= {h_st[1:0], ST_CP};
      h_ds <= {h_ds[1:0], DS};
      m_cnt <= n_cnt; m_word <= n_word; m_data <= n_data;
      m_vld <= n_vld; m_ferr <= n_ferr; m_ovr <= n_ovr;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("cyc_data_out", 32'(Data_out), 32'(m_data));
      check("cyc_data_vld", 32'(Data_vld), 32'(m_vld));
      check("cyc_frm_err",  32'(Frm_err),  32'(m_ferr));
      check("cyc_overrun",  32'(Overrun),  32'(m_ovr));
    end
    if (Frm_err === 1'b1) ferr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge Clk);
    #1;
    if (rand_mode) begin
      Data_ack = ($urandom_range(0, 3) == 0);
      Ovr_clr  = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  function automatic int ph();
    return rand_mode ? int'($urandom_range(2, 4)) : 3;
  endfunction

  task automatic send_bit(input logic b);
    DS = b; SH_CP = 1'b0;
    hold(ph());
    SH_CP = 1'b1;
    hold(ph());
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic latch();
    ST_CP = 1'b1;
    hold(ph());
    ST_CP = 1'b0;
    hold(ph());
  endtask

  // Shift and latch clocks rise in the same cycle.
  task automatic bit_latch(input logic b);
    DS = b; SH_CP = 1'b0;
    hold(ph());
    SH_CP = 1'b1; ST_CP = 1'b1;
    hold(ph());
    ST_CP = 1'b0;
    hold(ph());
  endtask

  // Latch with Data_ack landing on the capture edge.
  task automatic latch_ack();
    ST_CP = 1'b1;
    step(); step();
    Data_ack = 1'b1;
    step();
    Data_ack = 1'b0; ST_CP = 1'b0;
    hold(3);
  endtask

  task automatic pulse_ack();
    Data_ack = 1'b1; step(); Data_ack = 1'b0; step();
  endtask

  task automatic pulse_clr();
    Ovr_clr = 1'b1; step(); Ovr_clr = 1'b0; step();
  endtask

  int base;
  int unsigned nb;
  logic [31:0] rw;

  initial begin
    Rst = 1'b1; SH_CP = 1'b0; ST_CP = 1'b0; DS = 1'b0;
    Data_ack = 1'b0; Ovr_clr = 1'b0;
    hold(3);
    chk_en = 1'b1;
    check("rst_data_out", 32'(Data_out), 32'h0);
    check("rst_data_vld", 32'(Data_vld), 32'h0);
    check("rst_frm_err",  32'(Frm_err),  32'h0);
    check("rst_overrun",  32'(Overrun),  32'h0);
    Rst = 1'b0;
    step();

    // Loop-back: first latch ignored, then A5C3.
    base = ferr_cnt;
    latch();
    check("first_latch_vld", 32'(Data_vld), 32'h0);
    send_word(32'hA5C3, 16);
    latch();
    check("a5c3_data", 32'(Data_out), 32'hA5C3);
    check("a5c3_model", 32'(m_data), 32'hA5C3);
    check("a5c3_vld", 32'(Data_vld), 32'h1);
    check("a5c3_no_ferr", 32'(ferr_cnt - base), 32'h0);
    pulse_ack();

    // Ack, then overrun and its clear.
    send_word(32'h8001, 16); latch();
    check("8001_data", 32'(Data_out), 32'h8001);
    pulse_ack();
    check("8001_acked_vld", 32'(Data_vld), 32'h0);
    send_word(32'h1234, 16); latch();
    send_word(32'hBEEF, 16); latch();
    check("beef_data", 32'(Data_out), 32'hBEEF);
    check("beef_overrun", 32'(Overrun), 32'h1);
    check("beef_model_ovr", 32'(m_ovr), 32'h1);
    pulse_clr();
    check("ovr_cleared", 32'(Overrun), 32'h0);
    pulse_ack();

    // Short frame.
    base = ferr_cnt;
    send_word(32'h5A5A, 15); latch();
    check("short_ferr_pulses", 32'(ferr_cnt - base), 32'h1);
    check("short_data_kept", 32'(Data_out), 32'hBEEF);
    check("short_vld_kept", 32'(Data_vld), 32'h0);
    send_word(32'h00FF, 16); latch();
    check("00ff_data", 32'(Data_out), 32'h00FF);
    pulse_ack();

    // Long frame: count saturates, no capture.
    base = ferr_cnt;
    send_word(32'h3, 2); send_word(32'hC35A, 16); latch();
    check("long_ferr_pulses", 32'(ferr_cnt - base), 32'h1);
    check("long_data_kept", 32'(Data_out), 32'h00FF);
    check("long_vld_kept", 32'(Data_vld), 32'h0);

    // Coincident shift and latch.
    send_word(32'h7E81, 16);
    bit_latch(1'b1);
    check("7e81_data", 32'(Data_out), 32'h7E81);
    pulse_ack();
    send_word(32'h7FFF, 15); latch();
    check("ffff_data", 32'(Data_out), 32'hFFFF);
    check("ffff_model", 32'(m_data), 32'hFFFF);
    pulse_clr();

    // Ack in the capture cycle while valid.
    send_word(32'h3C96, 16);
    latch_ack();
    check("ackcap_data", 32'(Data_out), 32'h3C96);
    check("ackcap_vld", 32'(Data_vld), 32'h1);
    check("ackcap_ovr", 32'(Overrun), 32'h0);

    // Asynchronous reset mid-frame.
    send_word(32'h15, 5);
    #2 Rst = 1'b1; SH_CP = 1'b0;
    #1;
    check("async_rst_data", 32'(Data_out), 32'h0);
    check("async_rst_vld", 32'(Data_vld), 32'h0);
    check("async_rst_ovr", 32'(Overrun), 32'h0);
    hold(2);
    Rst = 1'b0;
    step();
    base = ferr_cnt;
    send_word(32'h5, 3); latch();
    check("post_rst_ferr", 32'(ferr_cnt - base), 32'h1);
    check("post_rst_vld", 32'(Data_vld), 32'h0);

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int f = 0; f < 60; f++) begin
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 19) : 16;
      rw = $urandom;
      for (int i = int'(nb) - 1; i >= 0; i--) send_bit(rw[i]);
      if ($urandom_range(0, 5) == 0) bit_latch(1'($urandom_range(0, 1)));
      else latch();
    end
    rand_mode = 1'b0;
    Data_ack = 1'b0; Ovr_clr = 1'b0;
    hold(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
